// File: rtl/bfly_r2_stage_par_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bfly_r2_stage_par_if                                       |
// | Description : Sample bus of the parallel radix-2 butterfly stage. It     |
// |               carries the input beat with its control and the two output |
// |               paths. The sat_flag member exists only when BFLY_SAT_EN    |
// |               is defined.                                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface bfly_r2_stage_par_if #(
    parameter int IN_W    = 9,
    parameter int OUT_W   = 10,
    parameter int LANES   = 16,
    parameter int BLK_CYC = 16
);
    localparam int c_beat_w = $clog2(BLK_CYC);

    logic                         valid_in;
    logic                         blk_clr;
    logic                         scale_en;
    logic [LANES-1:0][IN_W-1:0]   in_a_real;
    logic [LANES-1:0][IN_W-1:0]   in_a_imag;
    logic [LANES-1:0][IN_W-1:0]   in_b_real;
    logic [LANES-1:0][IN_W-1:0]   in_b_imag;

    logic                         valid_out;
    logic                         last_out;
    logic [c_beat_w-1:0]          beat_out;
    logic [LANES-1:0][OUT_W-1:0]  out_add_real;
    logic [LANES-1:0][OUT_W-1:0]  out_add_imag;
    logic [LANES-1:0][OUT_W-1:0]  out_sub_real;
    logic [LANES-1:0][OUT_W-1:0]  out_sub_imag;
`ifdef BFLY_SAT_EN
    logic                         sat_flag;
`endif

    // Upstream side: produces sample pairs, consumes results
    modport master (
`ifdef BFLY_SAT_EN
        input  sat_flag,
`endif
        output valid_in, blk_clr, scale_en,
        output in_a_real, in_a_imag, in_b_real, in_b_imag,
        input  valid_out, last_out, beat_out,
        input  out_add_real, out_add_imag, out_sub_real, out_sub_imag
    );

    // Butterfly side
    modport slave (
`ifdef BFLY_SAT_EN
        output sat_flag,
`endif
        input  valid_in, blk_clr, scale_en,
        input  in_a_real, in_a_imag, in_b_real, in_b_imag,
        output valid_out, last_out, beat_out,
        output out_add_real, out_add_imag, out_sub_real, out_sub_imag
    );
endinterface
`default_nettype wire

// File: rtl/bfly_r2_stage_par.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bfly_r2_stage_par                                          |
// | Description : Parallel radix-2 DIF butterfly stage. Per lane it outputs  |
// |               a+b and (a-b)*W with W in {1, -j} chosen from the in-block |
// |               beat index. Two register stages (input, output), block     |
// |               beat counter with clear, per-block divide-by-2 scaling.    |
// |               Optional macro BFLY_SAT_EN: clamp to the OUT_W range and   |
// |               raise a sticky sat_flag instead of wrapping.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bfly_r2_stage_par #(
    parameter int IN_W    = 9,
    parameter int OUT_W   = 10,
    parameter int LANES   = 16,
    parameter int BLK_CYC = 16,
    parameter int TW_MODE = 1
) (
    input  logic               clk,
    input  logic               rstn,
    bfly_r2_stage_par_if.slave bus
);
    localparam int c_beat_w = $clog2(BLK_CYC);
    // Sum/difference width: one growth bit, so neither can overflow
    localparam int c_sum_w  = IN_W + 1;
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BLK_CYC - 1);
`ifdef BFLY_SAT_EN
    localparam int c_out_max = (2 ** (OUT_W - 1)) - 1;
    localparam int c_out_min = -(2 ** (OUT_W - 1));
`endif

    // (x + 1) >>> 1 rewritten as (x >>> 1) + lsb: identical result, no extra bit
    function automatic logic signed [c_sum_w-1:0] scale_half(
        input logic signed [c_sum_w-1:0] x,
        input logic                      en
    );
        if (en) begin
            scale_half = (x >>> 1) + $signed({{(c_sum_w-1){1'b0}}, x[0]});
        end else begin
            scale_half = x;
        end
    endfunction

`ifdef BFLY_SAT_EN
    // Returns {overflow, value}: value clamped to the signed OUT_W range
    function automatic logic [OUT_W:0] fit_out(input logic signed [c_sum_w-1:0] x);
        int v;
        v = int'(x);
        if (v > c_out_max) begin
            fit_out = {1'b1, OUT_W'(c_out_max)};
        end else if (v < c_out_min) begin
            fit_out = {1'b1, OUT_W'(c_out_min)};
        end else begin
            fit_out = {1'b0, OUT_W'(x)};
        end
    endfunction
`else
    // Sign-extends when OUT_W is wider, wraps (drops MSBs) when narrower
    function automatic logic [OUT_W-1:0] fit_out(input logic signed [c_sum_w-1:0] x);
        fit_out = OUT_W'(x);
    endfunction
`endif

    // ---------------------------------------------------------------- stage 1
    logic [c_beat_w-1:0]        cnt_q, cnt_d;
    logic                       scale_lat_q, scale_lat_d;
    logic [c_beat_w-1:0]        w_beat_idx;
    logic                       w_beat_scale;

    logic                       s1_valid_q;
    logic                       s1_scale_q;
    logic [c_beat_w-1:0]        s1_beat_q;
    logic [LANES-1:0][IN_W-1:0] s1_ar_q, s1_ai_q, s1_br_q, s1_bi_q;

    // Beat counter next state; index and block scale of the beat being accepted
    always_comb begin
        cnt_d        = cnt_q;
        scale_lat_d  = scale_lat_q;
        w_beat_idx   = bus.blk_clr ? '0 : cnt_q;
        w_beat_scale = scale_lat_q;
        if (bus.blk_clr) begin
            cnt_d = bus.valid_in ? c_beat_w'(1) : '0;
        end else if (bus.valid_in) begin
            cnt_d = cnt_q + c_beat_w'(1);
        end
        // Scale is sampled only at block start and then governs the whole block
        if (bus.valid_in && (w_beat_idx == '0)) begin
            scale_lat_d  = bus.scale_en;
            w_beat_scale = bus.scale_en;
        end
    end

    // Input register: captures operands with their own beat index and scale
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q       <= '0;
            scale_lat_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_scale_q  <= 1'b0;
            s1_beat_q   <= '0;
            s1_ar_q     <= '0;
            s1_ai_q     <= '0;
            s1_br_q     <= '0;
            s1_bi_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            scale_lat_q <= scale_lat_d;
            s1_valid_q  <= bus.valid_in;
            if (bus.valid_in) begin
                s1_beat_q  <= w_beat_idx;
                s1_scale_q <= w_beat_scale;
                s1_ar_q    <= bus.in_a_real;
                s1_ai_q    <= bus.in_a_imag;
                s1_br_q    <= bus.in_b_real;
                s1_bi_q    <= bus.in_b_imag;
            end
        end
    end

    // ---------------------------------------------------------------- twiddle
    logic w_tw;
    if (TW_MODE == 1) begin : g_tw_half
        assign w_tw = s1_beat_q[c_beat_w-1];
    end else if (TW_MODE == 2) begin : g_tw_quarter
        assign w_tw = s1_beat_q[c_beat_w-2];
    end else begin : g_tw_none
        assign w_tw = 1'b0;
    end

    // ---------------------------------------------------------------- stage 2
`ifdef BFLY_SAT_EN
    logic [LANES-1:0] w_lane_ovf;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [c_sum_w-1:0] w_ar, w_ai, w_br, w_bi;
        logic signed [c_sum_w-1:0] w_sum_r, w_sum_i, w_dif_r, w_dif_i;
        logic signed [c_sum_w-1:0] w_tw_r, w_tw_i;
        logic [OUT_W-1:0]          add_r_d, add_i_d, sub_r_d, sub_i_d;
        logic [OUT_W-1:0]          add_r_q, add_i_q, sub_r_q, sub_i_q;

        assign w_ar    = c_sum_w'($signed(s1_ar_q[l]));
        assign w_ai    = c_sum_w'($signed(s1_ai_q[l]));
        assign w_br    = c_sum_w'($signed(s1_br_q[l]));
        assign w_bi    = c_sum_w'($signed(s1_bi_q[l]));
        assign w_sum_r = w_ar + w_br;
        assign w_sum_i = w_ai + w_bi;
        assign w_dif_r = w_ar - w_br;
        assign w_dif_i = w_ai - w_bi;
        // -j: (r, i) -> (i, -r); |difference| < 2^IN_W so the negation is exact
        assign w_tw_r  = w_tw ? w_dif_i  : w_dif_r;
        assign w_tw_i  = w_tw ? -w_dif_r : w_dif_i;

`ifdef BFLY_SAT_EN
        logic [OUT_W:0] w_fit_ar, w_fit_ai, w_fit_sr, w_fit_si;
        assign w_fit_ar = fit_out(scale_half(w_sum_r, s1_scale_q));
        assign w_fit_ai = fit_out(scale_half(w_sum_i, s1_scale_q));
        assign w_fit_sr = fit_out(scale_half(w_tw_r, s1_scale_q));
        assign w_fit_si = fit_out(scale_half(w_tw_i, s1_scale_q));
        assign add_r_d  = w_fit_ar[OUT_W-1:0];
        assign add_i_d  = w_fit_ai[OUT_W-1:0];
        assign sub_r_d  = w_fit_sr[OUT_W-1:0];
        assign sub_i_d  = w_fit_si[OUT_W-1:0];
        assign w_lane_ovf[l] = w_fit_ar[OUT_W] | w_fit_ai[OUT_W]
                             | w_fit_sr[OUT_W] | w_fit_si[OUT_W];
`else
        assign add_r_d = fit_out(scale_half(w_sum_r, s1_scale_q));
        assign add_i_d = fit_out(scale_half(w_sum_i, s1_scale_q));
        assign sub_r_d = fit_out(scale_half(w_tw_r, s1_scale_q));
        assign sub_i_d = fit_out(scale_half(w_tw_i, s1_scale_q));
`endif

        // Output register: loads on a valid beat, otherwise holds its value
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                add_r_q <= '0;
                add_i_q <= '0;
                sub_r_q <= '0;
                sub_i_q <= '0;
            end else if (s1_valid_q) begin
                add_r_q <= add_r_d;
                add_i_q <= add_i_d;
                sub_r_q <= sub_r_d;
                sub_i_q <= sub_i_d;
            end
        end

        assign bus.out_add_real[l] = add_r_q;
        assign bus.out_add_imag[l] = add_i_q;
        assign bus.out_sub_real[l] = sub_r_q;
        assign bus.out_sub_imag[l] = sub_i_q;
    end

    logic                valid_out_q;
    logic [c_beat_w-1:0] beat_out_q;

    // Output valid and beat index travel alongside the data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out_q <= 1'b0;
            beat_out_q  <= '0;
        end else begin
            valid_out_q <= s1_valid_q;
            if (s1_valid_q) begin
                beat_out_q <= s1_beat_q;
            end
        end
    end

    assign bus.valid_out = valid_out_q;
    assign bus.beat_out  = beat_out_q;
    assign bus.last_out  = valid_out_q && (beat_out_q == c_last_beat);

`ifdef BFLY_SAT_EN
    logic sat_q, sat_d;

    // Sticky clamp indicator; a block clear wipes it, a new clamp sets it
    always_comb begin
        sat_d = bus.blk_clr ? 1'b0 : sat_q;
        if (s1_valid_q && (|w_lane_ovf)) begin
            sat_d = 1'b1;
        end
    end

    // Clamp indicator register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign bus.sat_flag = sat_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_bfly_r2_stage_par.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bfly_r2_stage_par                                       |
// | Description : Directed, table-driven bench for bfly_r2_stage_par.        |
// |               dut1: default parameters (TW_MODE 1, OUT_W 10).            |
// |               dut2: TW_MODE 2, OUT_W 9 (quarter twiddle, wrap/clamp).    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bfly_r2_stage_par;
    localparam int IW = 9;
    localparam int LN = 16;
    localparam int NV = 45;

    typedef struct {
        bit v, c, s;
        int ar, ai, br, bi;
        bit ev;
        int eb;
        bit el;
        int xar, xai, xsr, xsi;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    bfly_r2_stage_par_if #(.IN_W(9), .OUT_W(10), .LANES(16), .BLK_CYC(16)) bus1 ();
    bfly_r2_stage_par_if #(.IN_W(9), .OUT_W(9),  .LANES(16), .BLK_CYC(16)) bus2 ();

    bfly_r2_stage_par #(.IN_W(9), .OUT_W(10), .LANES(16), .BLK_CYC(16), .TW_MODE(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1.slave)
    );
    bfly_r2_stage_par #(.IN_W(9), .OUT_W(9), .LANES(16), .BLK_CYC(16), .TW_MODE(2)) dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2.slave)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic setv(input int k, input bit v, c, s, input int ar, ai, br, bi,
                        input bit ev, input int eb, input bit el,
                        input int xar, xai, xsr, xsi);
        tbl[k].v  = v;   tbl[k].c  = c;   tbl[k].s  = s;
        tbl[k].ar = ar;  tbl[k].ai = ai;  tbl[k].br = br;  tbl[k].bi = bi;
        tbl[k].ev = ev;  tbl[k].eb = eb;  tbl[k].el = el;
        tbl[k].xar = xar; tbl[k].xai = xai; tbl[k].xsr = xsr; tbl[k].xsi = xsi;
    endtask

    task automatic drv1(input bit v, c, s, input int ar, ai, br, bi);
        bus1.valid_in = v;
        bus1.blk_clr  = c;
        bus1.scale_en = s;
        for (int l = 0; l < LN; l++) begin
            bus1.in_a_real[l] = IW'(ar);
            bus1.in_a_imag[l] = IW'(ai);
            bus1.in_b_real[l] = IW'(br);
            bus1.in_b_imag[l] = IW'(bi);
        end
    endtask

    task automatic drv2(input bit v, c, s, input int ar, ai, br, bi);
        bus2.valid_in = v;
        bus2.blk_clr  = c;
        bus2.scale_en = s;
        for (int l = 0; l < LN; l++) begin
            bus2.in_a_real[l] = IW'(ar);
            bus2.in_a_imag[l] = IW'(ai);
            bus2.in_b_real[l] = IW'(br);
            bus2.in_b_imag[l] = IW'(bi);
        end
    endtask

    task automatic check1(input string tag, input bit ev, input int eb, input bit el,
                          input int xar, xai, xsr, xsi);
        chk({tag, " valid_out"}, int'(bus1.valid_out), int'(ev));
        chk({tag, " beat_out"},  int'(bus1.beat_out),  eb);
        chk({tag, " last_out"},  int'(bus1.last_out),  int'(el));
        for (int l = 0; l < LN; l++) begin
            chk($sformatf("%s lane%0d add_re", tag, l), int'($signed(bus1.out_add_real[l])), xar);
            chk($sformatf("%s lane%0d add_im", tag, l), int'($signed(bus1.out_add_imag[l])), xai);
            chk($sformatf("%s lane%0d sub_re", tag, l), int'($signed(bus1.out_sub_real[l])), xsr);
            chk($sformatf("%s lane%0d sub_im", tag, l), int'($signed(bus1.out_sub_imag[l])), xsi);
        end
    endtask

    task automatic check2(input string tag, input bit ev, input int eb, input bit el,
                          input int xar, xai, xsr, xsi);
        chk({tag, " valid_out"}, int'(bus2.valid_out), int'(ev));
        chk({tag, " beat_out"},  int'(bus2.beat_out),  eb);
        chk({tag, " last_out"},  int'(bus2.last_out),  int'(el));
        for (int l = 0; l < LN; l++) begin
            chk($sformatf("%s lane%0d add_re", tag, l), int'($signed(bus2.out_add_real[l])), xar);
            chk($sformatf("%s lane%0d add_im", tag, l), int'($signed(bus2.out_add_imag[l])), xai);
            chk($sformatf("%s lane%0d sub_re", tag, l), int'($signed(bus2.out_sub_real[l])), xsr);
            chk($sformatf("%s lane%0d sub_im", tag, l), int'($signed(bus2.out_sub_imag[l])), xsi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "time limit");
    end

    initial begin
        // Block 1: 16 continuous beats; -j on beats 8..15
        for (int k = 0; k < 16; k++)
            setv(k, 1'b1, 1'b0, 1'b0, 100, -50, 20, 10, 1'b1, k, (k == 15),
                 120, -40, (k < 8) ? 80 : -60, (k < 8) ? -60 : -80);
        // Gaps 1,0,0,1,1 starting at the wrapped beat 0 (17th beat)
        setv(16, 1'b1, 1'b0, 1'b0, 10, 20, 1, 2,  1'b1, 0, 1'b0, 11, 22, 9, 18);
        setv(17, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0,    1'b0, 0, 1'b0, 11, 22, 9, 18);
        setv(18, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0,    1'b0, 0, 1'b0, 11, 22, 9, 18);
        setv(19, 1'b1, 1'b0, 1'b0, -5, 7, 6, -8,  1'b1, 1, 1'b0, 1, -1, -11, 15);
        setv(20, 1'b1, 1'b0, 1'b0, -5, 7, 6, -8,  1'b1, 2, 1'b0, 1, -1, -11, 15);
        // Extreme operands on beats 3..8; beat 8 is in the -j half
        for (int k = 0; k < 6; k++)
            setv(21 + k, 1'b1, 1'b0, 1'b0, 255, -256, -256, 255, 1'b1, 3 + k, 1'b0,
                 -1, -1, (3 + k < 8) ? 511 : -511, -511);
        // blk_clr with a valid beat at beat 9: reported as beat 0, scaled block
        setv(27, 1'b1, 1'b1, 1'b1, 3, -3, 0, 0, 1'b1, 0, 1'b0, 2, -1, 2, -1);
        for (int k = 1; k < 16; k++)
            setv(27 + k, 1'b1, 1'b0, (k < 3), 3, -3, 0, 0, 1'b1, k, (k == 15),
                 2, -1, (k < 8) ? 2 : -1, -1);
        // Next block unscaled; scale_en rising mid-block is ignored
        setv(43, 1'b1, 1'b0, 1'b0, 3, -3, 0, 0, 1'b1, 0, 1'b0, 3, -3, 3, -3);
        setv(44, 1'b1, 1'b0, 1'b1, 3, -3, 0, 0, 1'b1, 1, 1'b0, 3, -3, 3, -3);

        rstn = 1'b0;
        drv1(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        drv2(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check1("reset1", 1'b0, 0, 1'b0, 0, 0, 0, 0);
        check2("reset2", 1'b0, 0, 1'b0, 0, 0, 0, 0);
`ifdef BFLY_SAT_EN
        chk("reset sat_flag", int'(bus2.sat_flag), 0);
`endif
        rstn = 1'b1;

        // Table: record k is driven in iteration k and observed two edges later
        for (int i = 0; i <= NV; i++) begin
            if (i < NV)
                drv1(tbl[i].v, tbl[i].c, tbl[i].s, tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi);
            else
                drv1(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            if (i >= 1)
                check1($sformatf("vec%0d", i - 1), tbl[i - 1].ev, tbl[i - 1].eb, tbl[i - 1].el,
                       tbl[i - 1].xar, tbl[i - 1].xai, tbl[i - 1].xsr, tbl[i - 1].xsi);
        end

        // TW_MODE 2: -j on beats 4..7 and 12..15 only
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drv2(1'b1, 1'b0, 1'b0, 10, 0, 0, 5);
            else        drv2(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            if (i >= 1) begin
                int  j;
                bit  tw;
                j  = i - 1;
                tw = ((j % 8) >= 4);
                check2($sformatf("tw2 beat%0d", j), 1'b1, j, (j == 15),
                       10, 5, tw ? -5 : 10, tw ? -10 : -5);
            end
        end

        // OUT_W 9: 255 + 255 does not fit
        drv2(1'b1, 1'b0, 1'b0, 255, 0, 255, 0);
        @(posedge clk);
        #1;
        drv2(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
`ifdef BFLY_SAT_EN
        check2("sat", 1'b1, 0, 1'b0, 255, 0, 0, 0);
        chk("sat sat_flag", int'(bus2.sat_flag), 1);
        chk("sat dut1 sat_flag", int'(bus1.sat_flag), 0);
        drv2(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drv2(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        chk("sat cleared by blk_clr", int'(bus2.sat_flag), 0);
`else
        check2("wrap", 1'b1, 0, 1'b0, -2, 0, 0, 0);
`endif

        // Asynchronous reset in the middle of beat 5
        drv1(1'b1, 1'b1, 1'b0, 1, 1, 1, 1);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 4; k++) begin
            drv1(1'b1, 1'b0, 1'b0, 1, 1, 1, 1);
            @(posedge clk);
            #1;
        end
        check1("pre-reset", 1'b1, 3, 1'b0, 2, 2, 0, 0);
        drv1(1'b1, 1'b0, 1'b0, 1, 1, 1, 1);
        #1;
        rstn = 1'b0;
        #1;
        check1("mid-reset", 1'b0, 0, 1'b0, 0, 0, 0, 0);
        drv1(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        drv1(1'b1, 1'b0, 1'b0, 7, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("post-reset latency valid_out", int'(bus1.valid_out), 0);
        drv1(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check1("post-reset", 1'b1, 0, 1'b0, 7, 0, 7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bfly_r2_stage_par.md
Name: bfly_r2_stage_par

Overview:
- Parametrised radix-2 DIF butterfly stage for the parallel FFT datapath. Processes LANES sample pairs per cycle over blocks of BLK_CYC valid beats.
- Per lane it outputs a+b and (a-b)·W, where W is a trivial twiddle (1 or -j) selected from the in-block beat index according to TW_MODE.
- Adds block wrap-around, a runtime divide-by-2 scaling option, a block-clear input and a last-beat marker.
- Sits between the shift-register/reorder buffers and the next butterfly or twiddle-multiply stage.

Parameters:
- IN_W, 9, input component width (signed two's complement)
- OUT_W, 10, output component width (signed); must be >= IN_W
- LANES, 16, parallel butterflies per cycle
- BLK_CYC, 16, valid beats per block; power of two, >= 4
- TW_MODE, 1, twiddle pattern: 0 = always 1; 1 = -j for beat >= BLK_CYC/2; 2 = -j for (beat mod BLK_CYC/2) >= BLK_CYC/4

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- valid_in  in  1  input beat valid
- blk_clr  in  1  synchronous beat-counter clear
- scale_en  in  1  divide results by 2; sampled at block start
- in_a_real  in  IN_W x LANES  operand A, real part
- in_a_imag  in  IN_W x LANES  operand A, imaginary part
- in_b_real  in  IN_W x LANES  operand B, real part
- in_b_imag  in  IN_W x LANES  operand B, imaginary part
- valid_out  out  1  output beat valid
- last_out  out  1  high on the output beat carrying beat index BLK_CYC-1
- beat_out  out  $clog2(BLK_CYC)  beat index of the current output
- out_add_real  out  OUT_W x LANES  real part of a+b
- out_add_imag  out  OUT_W x LANES  imaginary part of a+b
- out_sub_real  out  OUT_W x LANES  real part of (a-b)·W
- out_sub_imag  out  OUT_W x LANES  imaginary part of (a-b)·W

Behaviour:
- Reset (rstn low, asynchronous): all outputs are 0, the beat counter is 0, the latched scale is 0, and pipeline valids are 0. Reset asserted mid-block discards all in-flight beats. After release, the next valid beat is beat 0.
- Pipeline has two register stages: an input register, then an output register. valid_in at cycle T produces valid_out at T+2. There is no backpressure.
- Beat counter advances on each accepted valid_in and wraps from BLK_CYC-1 to 0. Cycles with valid_in low do not advance it.
- Outputs hold their last value while valid_out is low.
- blk_clr forces the counter to 0 at the next edge.
  - If valid_in is also high in that cycle, the beat is accepted as beat 0 and the counter goes to 1.
  - blk_clr does not flush beats already in the pipeline.
- scale_en is latched when a beat with index 0 is accepted and applies to the whole block. Changes to scale_en mid-block are ignored.
- Arithmetic:
  - Sum and difference are computed at IN_W+1 bits, so they cannot overflow.
  - Twiddle -j maps (r,i) to (i,-r). The difference range is ±(2^IN_W - 1), so negation is always exact.
  - The twiddle applies to the sub path only and uses the beat index of the beat being processed, not the current counter.
  - If the latched scale is 1: result = (x + 1) >>> 1 (arithmetic shift, round half up), applied after the twiddle.
  - The final result is sign-extended to OUT_W. If OUT_W < IN_W+1 after scaling, it is truncated to OUT_W bits (wraps) unless BFLY_SAT_EN is defined.
- last_out and beat_out are pipelined alongside the data. last_out = valid_out AND (beat_out == BLK_CYC-1).
- Back-to-back blocks with no gap are supported. Beat 0 of block N+1 follows beat BLK_CYC-1 of block N directly.

Optional Feature:
- Macro: BFLY_SAT_EN.
- Defined: each output component that exceeds the OUT_W range clamps to 2^(OUT_W-1)-1 or -2^(OUT_W-1), and a sticky output sat_flag (1 bit, reset 0) is set; it is cleared only by reset or blk_clr.
- Not defined: plain two's-complement truncation, and no sat_flag port exists.

Test Plan:
- Default parameters, 16 continuous beats, all lanes a=(100,-50), b=(20,10):
  - Beats 0–7: add=(120,-40), sub=(80,-60).
  - Beats 8–15: sub=(-60,-80).
  - last_out high only on the 16th output; valid_out arrives 2 cycles after valid_in.
- Gaps: valid_in pattern 1,0,0,1,1 → beat_out reads 0,1,2; outputs hold during the gaps; the counter wraps to 0 after beat 15 and the 17th beat reports beat_out=0.
- Scaling: scale_en=1 at beat 0, dropped to 0 at beat 3; a=(3,-3), b=(0,0) → add=(2,-1) for all 16 beats of that block. The next block is unscaled: add=(3,-3).
- Corners: a=(255,-256), b=(-256,255) → sub=(511,-511); in the -j half sub=(-511,-511). TW_MODE=2 → -j applied on beats 4–7 and 12–15 only.
- Reset asserted at beat 5 → all outputs 0 and valid_out 0 immediately; the first beat after release reports beat_out=0. blk_clr together with valid_in at beat 9 → that beat is reported as beat 0.
- BFLY_SAT_EN defined, OUT_W=9: a=(255,0), b=(255,0) → add_real=255 and sat_flag=1. Without the macro: add_real=-2 (wrapped).
